// File: rtl/tmds_rx_decoder.sv
// tmds_rx_decoder: receive side of the soc_video TMDS link.
// Classifies and decodes the three 10-bit TMDS symbols per pixel clock, recovers
// RGB/DE/HSYNC/VSYNC with a fixed two-cycle latency, tracks pixel coordinates and
// declares frame lock once LOCK_FRAMES consecutive frames have the expected geometry.
// Optional feature macro: TMDS_RX_STATS_EN adds frame_count and err_count outputs.
module tmds_rx_decoder #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk_pixel,
    input  logic        reset,
    input  logic [9:0]  tmds_r,
    input  logic [9:0]  tmds_g,
    input  logic [9:0]  tmds_b,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        locked,
    output logic        sym_err
`ifdef TMDS_RX_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] err_count
`endif
);

    localparam logic [10:0] H_LEN  = 11'(H_ACTIVE);
    localparam logic [9:0]  V_LEN  = 10'(V_ACTIVE);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    function automatic logic ctrl_valid(input logic [9:0] s);
        case (s)
            10'b1101010100, 10'b0010101011,
            10'b0101010100, 10'b1010101011: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // {C1,C0} carried by a control token; only meaningful when ctrl_valid is set
    function automatic logic [1:0] ctrl_code(input logic [9:0] s);
        case (s)
            10'b0010101011: return 2'b01;
            10'b0101010100: return 2'b10;
            10'b1010101011: return 2'b11;
            default:        return 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] x;
        q = s[9] ? ~s[7:0] : s[7:0];
        x = q ^ {q[6:0], 1'b0};
        return s[8] ? {x[7:1], q[0]} : {~x[7:1], q[0]};
    endfunction

    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    // stage 1 registers
    logic [9:0]  sym_r_q, sym_g_q, sym_b_q, sym_r_d, sym_g_d, sym_b_d;
    logic        ctl_r_q, ctl_g_q, ctl_b_q, ctl_r_d, ctl_g_d, ctl_b_d;
    logic [1:0]  cb_q, cb_d;

    // stage 2 registers
    logic [7:0]  pix_r_q, pix_g_q, pix_b_q, pix_r_d, pix_g_d, pix_b_d;
    logic        de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic        sym_err_q, sym_err_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic        frame_bad_q, frame_bad_d;

    // lock tracking
    lock_state_e state_q, state_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic        locked_q, locked_d;

    // stage 2 events
    logic        all_data, all_ctrl, mixed;
    logic        de_fall, vs_rise, line_bad, frame_good;
    logic [10:0] line_len;
    logic [9:0]  y_next;

    // Stage 1: capture symbols and classify each channel as control or data
    always_comb begin
        sym_r_d = tmds_r;
        sym_g_d = tmds_g;
        sym_b_d = tmds_b;
        ctl_r_d = ctrl_valid(tmds_r);
        ctl_g_d = ctrl_valid(tmds_g);
        ctl_b_d = ctrl_valid(tmds_b);
        cb_d    = ctrl_code(tmds_b);
    end

    // Stage 2: decode, sync recovery, coordinate counters and frame quality
    always_comb begin
        all_data = ~(ctl_r_q | ctl_g_q | ctl_b_q);
        all_ctrl = ctl_r_q & ctl_g_q & ctl_b_q;
        mixed    = ~all_data & ~all_ctrl;

        de_d      = all_data;
        sym_err_d = mixed;
        pix_r_d   = all_data ? tmds_decode(sym_r_q) : pix_r_q;
        pix_g_d   = all_data ? tmds_decode(sym_g_q) : pix_g_q;
        pix_b_d   = all_data ? tmds_decode(sym_b_q) : pix_b_q;
        hsync_d   = all_ctrl ? cb_q[0] : hsync_q;
        vsync_d   = all_ctrl ? cb_q[1] : vsync_q;

        de_fall = de_q & ~de_d;
        vs_rise = vsync_d & ~vsync_q;

        if (de_d) begin
            pix_x_d = de_q ? sat_inc(pix_x_q) : '0;
        end else if (de_fall) begin
            pix_x_d = '0;
        end else begin
            pix_x_d = pix_x_q;
        end

        line_len = {1'b0, pix_x_q} + 11'd1;
        line_bad = de_fall & (line_len != H_LEN);

        // a line ending in the same cycle as the vsync edge belongs to the closing frame
        y_next  = de_fall ? sat_inc(pix_y_q) : pix_y_q;
        pix_y_d = vs_rise ? '0 : y_next;

        frame_good  = ~(frame_bad_q | line_bad | mixed) & (y_next == V_LEN);
        frame_bad_d = vs_rise ? 1'b0 : (frame_bad_q | line_bad | mixed);
    end

    // Lock FSM: next state and lock counter
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d    = TRACK;
                    lock_cnt_d = '0;
                end
            end
            TRACK: begin
                if (vs_rise) begin
                    if (frame_good) begin
                        lock_cnt_d = lock_cnt_q + 4'd1;
                        if (lock_cnt_q + 4'd1 == LOCK_N) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || (vs_rise && !frame_good)) begin
                    state_d    = SEARCH;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = SEARCH;
                lock_cnt_d = '0;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // Pipeline and FSM registers; stage 1 resets to a C=00 control token so the
    // first cycle after reset does not look like a data symbol
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            sym_r_q     <= '0;
            sym_g_q     <= '0;
            sym_b_q     <= '0;
            ctl_r_q     <= 1'b1;
            ctl_g_q     <= 1'b1;
            ctl_b_q     <= 1'b1;
            cb_q        <= '0;
            pix_r_q     <= '0;
            pix_g_q     <= '0;
            pix_b_q     <= '0;
            de_q        <= 1'b0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            sym_err_q   <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            frame_bad_q <= 1'b0;
            state_q     <= SEARCH;
            lock_cnt_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            sym_r_q     <= sym_r_d;
            sym_g_q     <= sym_g_d;
            sym_b_q     <= sym_b_d;
            ctl_r_q     <= ctl_r_d;
            ctl_g_q     <= ctl_g_d;
            ctl_b_q     <= ctl_b_d;
            cb_q        <= cb_d;
            pix_r_q     <= pix_r_d;
            pix_g_q     <= pix_g_d;
            pix_b_q     <= pix_b_d;
            de_q        <= de_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            sym_err_q   <= sym_err_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            frame_bad_q <= frame_bad_d;
            state_q     <= state_d;
            lock_cnt_q  <= lock_cnt_d;
            locked_q    <= locked_d;
        end
    end

`ifdef TMDS_RX_STATS_EN
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] err_count_q, err_count_d;

    // Statistics: frame counter wraps, error counter saturates
    always_comb begin
        frame_count_d = vs_rise ? frame_count_q + 16'd1 : frame_count_q;
        err_count_d   = (mixed && err_count_q != '1) ? err_count_q + 16'd1 : err_count_q;
    end

    // Statistics registers
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`endif

    assign pix_r   = pix_r_q;
    assign pix_g   = pix_g_q;
    assign pix_b   = pix_b_q;
    assign de      = de_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign pix_x   = pix_x_q;
    assign pix_y   = pix_y_q;
    assign locked  = locked_q;
    assign sym_err = sym_err_q;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed bench for tmds_rx_decoder on a reduced 16x8 geometry.
module tb_tmds_rx_decoder;

    localparam int H = 16;
    localparam int V = 8;

    localparam logic [9:0] C00 = 10'b1101010100;
    localparam logic [9:0] C01 = 10'b0010101011;
    localparam logic [9:0] C10 = 10'b0101010100;
    localparam logic [9:0] C11 = 10'b1010101011;

    logic       clk_pixel = 1'b0;
    logic       reset;
    logic [9:0] tmds_r, tmds_g, tmds_b;
    logic [7:0] pix_r, pix_g, pix_b;
    logic       de, hsync, vsync, locked, sym_err;
    logic [9:0] pix_x, pix_y;
`ifdef TMDS_RX_STATS_EN
    logic [15:0] frame_count, err_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        bit chk;
        bit de;
        int x;
        int y;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t pipe [2];
    exp_t none;

    tmds_rx_decoder #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .LOCK_FRAMES (2)
    ) dut (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .tmds_r      (tmds_r),
        .tmds_g      (tmds_g),
        .tmds_b      (tmds_b),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .locked      (locked),
        .sym_err     (sym_err)
`ifdef TMDS_RX_STATS_EN
        ,
        .frame_count (frame_count),
        .err_count   (err_count)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Encode with q[9]=0, q[8]=1 (XOR chain); values below 0x80 never hit a control token
    function automatic logic [9:0] enc(input logic [7:0] d);
        logic [7:0] q;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = d[i] ^ q[i-1];
        return {2'b01, q};
    endfunction

    // One pixel clock: check outputs for the symbol applied two cycles ago, then drive
    task automatic cycle(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b,
                         input exp_t e);
        @(negedge clk_pixel);
        if (pipe[1].chk) begin
            check("de", 32'(de), 32'(pipe[1].de));
            check("sym_err", 32'(sym_err), 0);
            if (pipe[1].de) begin
                check("pix_x", 32'(pix_x), pipe[1].x);
                check("pix_y", 32'(pix_y), pipe[1].y);
                check("pix_r", 32'(pix_r), pipe[1].r);
                check("pix_g", 32'(pix_g), pipe[1].g);
                check("pix_b", 32'(pix_b), pipe[1].b);
            end
        end
        pipe[1] = pipe[0];
        pipe[0] = e;
        tmds_r = r;
        tmds_g = g;
        tmds_b = b;
    endtask

    task automatic idle();
        cycle(C00, C00, C00, none);
    endtask

    task automatic frame(input int short_line, input bit exp_lock);
        exp_t e;
        e = '{default: 0};
        e.chk = 1;
        repeat (4) cycle(C00, C00, C10, e);
        repeat (2) cycle(C00, C00, C00, e);
        check("lock_at_vs", 32'(locked), 32'(exp_lock));
        for (int y = 0; y < V; y++) begin
            e.de = 0;
            for (int k = 0; k < 6; k++) begin
                cycle(C00, C00, (k < 2) ? C01 : C00, e);
                if (short_line >= 0 && k == 3 && y == short_line + 1)
                    check("lock_drop", 32'(locked), 0);
            end
            for (int x = 0; x < ((y == short_line) ? H - 1 : H); x++) begin
                e.de = 1;
                e.x  = x;
                e.y  = y;
                e.r  = x & 'h7f;
                e.g  = y & 'h7f;
                e.b  = 'h11;
                cycle(enc(8'(e.r)), enc(8'(e.g)), enc(8'(e.b)), e);
            end
        end
    endtask

    initial begin
        exp_t blank;
        none    = '{default: 0};
        blank   = '{default: 0};
        blank.chk = 1;
        pipe[0] = none;
        pipe[1] = none;
        reset   = 1'b1;
        tmds_r  = C00;
        tmds_g  = C00;
        tmds_b  = C00;

        // reset with random symbols
        repeat (3) cycle(10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                         10'($urandom_range(0, 1023)), none);
        check("rst_de", 32'(de), 0);
        check("rst_hsync", 32'(hsync), 0);
        check("rst_vsync", 32'(vsync), 0);
        check("rst_sym_err", 32'(sym_err), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_pix_r", 32'(pix_r), 0);
        check("rst_pix_g", 32'(pix_g), 0);
        check("rst_pix_b", 32'(pix_b), 0);
        check("rst_pix_x", 32'(pix_x), 0);
        check("rst_pix_y", 32'(pix_y), 0);
`ifdef TMDS_RX_STATS_EN
        check("rst_frame_count", 32'(frame_count), 0);
        check("rst_err_count", 32'(err_count), 0);
`endif
        idle();
        reset = 1'b0;
        idle();
        idle();
        check("post_rst_de", 32'(de), 0);

        // hsync token on blue
        cycle(C00, C00, C01, none);
        idle();
        idle();
        check("tok01_hsync", 32'(hsync), 1);
        check("tok01_vsync", 32'(vsync), 0);
        check("tok01_de", 32'(de), 0);
        idle();
        check("tok00_hsync", 32'(hsync), 0);

        // both syncs
        cycle(C00, C00, C11, none);
        idle();
        idle();
        check("tok11_hsync", 32'(hsync), 1);
        check("tok11_vsync", 32'(vsync), 1);
        idle();
        check("tok00_vsync", 32'(vsync), 0);

        // data decode vectors
        cycle(10'h1FF, 10'h1AA, 10'h00F, none);
        cycle(10'h0FF, 10'h0FF, 10'h0FF, none);
        idle();
        check("dec1_de", 32'(de), 1);
        check("dec1_r", 32'(pix_r), 'h01);
        check("dec1_g", 32'(pix_g), 'hFE);
        check("dec1_b", 32'(pix_b), 'hEF);
        check("dec1_x", 32'(pix_x), 0);
        idle();
        check("dec2_de", 32'(de), 1);
        check("dec2_r", 32'(pix_r), 'hFF);
        check("dec2_g", 32'(pix_g), 'hFF);
        check("dec2_b", 32'(pix_b), 'hFF);
        check("dec2_x", 32'(pix_x), 1);
        idle();
        check("dec_end_de", 32'(de), 0);
        check("dec_end_hold_r", 32'(pix_r), 'hFF);
        check("dec_end_x", 32'(pix_x), 0);

        // channel disagreement
        cycle(10'h1FF, C00, C00, none);
        idle();
        idle();
        check("mix_sym_err", 32'(sym_err), 1);
        check("mix_de", 32'(de), 0);
        check("mix_hold_r", 32'(pix_r), 'hFF);
        check("mix_hold_g", 32'(pix_g), 'hFF);
        idle();
        check("mix_pulse_end", 32'(sym_err), 0);
`ifdef TMDS_RX_STATS_EN
        check("mix_err_count", 32'(err_count), 1);
`endif

        // full-frame stream, lock, short line, relock
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        idle();
        check("stream_rst_locked", 32'(locked), 0);
        frame(-1, 1'b0);
        frame(-1, 1'b0);
        frame(-1, 1'b1);
        frame(3, 1'b1);
        frame(-1, 1'b0);
        frame(-1, 1'b0);
        frame(-1, 1'b1);
        repeat (3) cycle(C00, C00, C00, blank);
        check("final_locked", 32'(locked), 1);
`ifdef TMDS_RX_STATS_EN
        check("final_frame_count", 32'(frame_count), 7);
        check("final_err_count", 32'(err_count), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
